// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_if
//  Description : MEM-stage request/response bundle between the EX/MEM
//                register side (master) and the data-memory responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Address_i;
    logic [31:0] WriteData_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        ack_o;
    logic        err_o;

    modport master (
        output MemRead_i, MemWrite_i, Address_i, WriteData_i,
        input  data_o, stall_o, ack_o, err_o
    );

    modport slave (
        input  MemRead_i, MemWrite_i, Address_i, WriteData_i,
        output data_o, stall_o, ack_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Fixed-latency data memory for the MEM stage; stalls the
//                pipeline while an access is in flight, then acks for one cycle.
//                Optional misalignment rejection: define DMEM_ALIGN_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    data_mem_responder_if.slave bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic            r_is_read;
    logic            r_reject;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [31:0]     r_data;
    logic [31:0]     mem [DEPTH];

    logic            w_req;
    logic            w_reject;
    logic            w_misalign;
    logic            w_last_busy;
    logic            w_stall;
    logic            w_ack;
    logic            w_err;

    assign w_req = bus.MemRead_i | bus.MemWrite_i;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign = |bus.Address_i[1:0];
`else
    // Byte offset is deliberately dropped; the word index is used as-is.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.Address_i[1:0];
    assign w_misalign      = 1'b0;
`endif

    assign w_reject    = (bus.MemRead_i & bus.MemWrite_i)
                       | (|bus.Address_i[31:AW+2])
                       | w_misalign;
    assign w_last_busy = (r_state == BUSY) && (r_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_ack        = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_stall      = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_ack        = 1'b1;
                w_err        = r_reject;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Stall is forced low while reset is applied so the hazard unit never freezes on it.
    assign bus.stall_o = w_stall & ~rst_i;
    assign bus.ack_o   = w_ack;
    assign bus.err_o   = w_err;
    assign bus.data_o  = r_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_data    <= '0;
            r_is_read <= 1'b0;
            r_reject  <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
        end else begin
            r_data <= '0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_is_read <= bus.MemRead_i;
                        r_reject  <= w_reject;
                        r_idx     <= bus.Address_i[AW+1:2];
                        r_wdata   <= bus.WriteData_i;
                        r_cnt     <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (r_is_read && !r_reject) begin
                        r_data <= mem[r_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is not reset; a reset on the commit edge discards the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_last_busy && !r_is_read && !r_reject) begin
            mem[r_idx] <= r_wdata;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Randomized self-checking bench with an array-based memory
//                reference model and fixed-latency response expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ref_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_reject(input bit rd, input bit wr, input logic [31:0] a);
        bit e;
        e = (rd && wr) || (a >= 32'(DEPTH * 4));
`ifdef DMEM_ALIGN_CHECK_EN
        if ((a % 4) != 0) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic drive_idle();
        bus.MemRead_i   = 1'b0;
        bus.MemWrite_i  = 1'b0;
        bus.Address_i   = 32'h0;
        bus.WriteData_i = 32'h0;
    endtask

    // rcyc: 0 = no reset, 1..LAT = reset in that BUSY cycle, LAT+1 = reset in DONE
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input int rcyc);
        bit          e;
        int          idx;
        logic [31:0] exp_d;
        e     = exp_reject(rd, wr, a);
        idx   = int'((a / 4) % DEPTH);
        exp_d = (!e && rd) ? ref_mem[idx] : 32'h0;

        @(posedge clk); #1;
        bus.MemRead_i   = rd;
        bus.MemWrite_i  = wr;
        bus.Address_i   = a;
        bus.WriteData_i = wd;
        @(negedge clk);
        check("stall_req_cycle", {31'h0, bus.stall_o}, 32'h1);
        check("ack_req_cycle",   {31'h0, bus.ack_o},   32'h0);
        check("data_req_cycle",  bus.data_o,           32'h0);

        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            if (rcyc == k) begin
                rst = 1'b1;
                @(negedge clk);
                check("stall_in_reset", {31'h0, bus.stall_o}, 32'h0);
                @(posedge clk); #1;
                rst = 1'b0;
                drive_idle();
                @(negedge clk);
                check("ack_after_abort",   {31'h0, bus.ack_o},   32'h0);
                check("stall_after_abort", {31'h0, bus.stall_o}, 32'h0);
                return;
            end
            bus.MemRead_i   = 1'($urandom);
            bus.MemWrite_i  = 1'($urandom);
            bus.Address_i   = $urandom;
            bus.WriteData_i = $urandom;
            @(negedge clk);
            check("stall_busy", {31'h0, bus.stall_o}, 32'h1);
            check("ack_busy",   {31'h0, bus.ack_o},   32'h0);
        end

        @(posedge clk); #1;
        drive_idle();
        if (!e && wr && !rd) ref_mem[idx] = wd;
        if (rcyc == LAT + 1) rst = 1'b1;
        @(negedge clk);
        check("ack_done",   {31'h0, bus.ack_o},   32'h1);
        check("err_done",   {31'h0, bus.err_o},   {31'h0, e});
        check("data_done",  bus.data_o,           exp_d);
        check("stall_done", {31'h0, bus.stall_o}, 32'h0);
        if (rcyc == LAT + 1) begin
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check("ack_after_done_rst",  {31'h0, bus.ack_o}, 32'h0);
            check("err_after_done_rst",  {31'h0, bus.err_o}, 32'h0);
            check("data_after_done_rst", bus.data_o,         32'h0);
        end
    endtask

    function automatic logic [31:0] pool_addr();
        int w;
        w = $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1) w = DEPTH - 1 - w;
        return 32'(w * 4);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          sel;
        bit          rd;
        bit          wr;

        rst             = 1'b1;
        bus.MemRead_i   = 1'b1;
        bus.MemWrite_i  = 1'b0;
        bus.Address_i   = 32'h10;
        bus.WriteData_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {31'h0, bus.stall_o}, 32'h0);
        check("reset_ack",   {31'h0, bus.ack_o},   32'h0);
        check("reset_err",   {31'h0, bus.err_o},   32'h0);
        check("reset_data",  bus.data_o,           32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();

        for (int w = 0; w < 16; w++) begin
            access(1'b0, 1'b1, 32'(w * 4), $urandom, 0);
            access(1'b0, 1'b1, 32'((DEPTH - 1 - w) * 4), $urandom, 0);
        end

        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        access(1'b1, 1'b0, 32'h10, 32'h0, 0);
        access(1'b1, 1'b0, 32'h0, 32'h0, 0);
        access(1'b1, 1'b0, 32'h4, 32'h0, 0);
        access(1'b0, 1'b1, 32'h400, 32'h12345678, 0);
        access(1'b1, 1'b0, 32'h0, 32'h0, 0);
        access(1'b1, 1'b1, 32'h8, 32'hFFFF0000, 0);
        access(1'b1, 1'b0, 32'h8, 32'h0, 0);
        access(1'b0, 1'b1, 32'h20, 32'h11112222, 0);
        access(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, LAT);
        access(1'b1, 1'b0, 32'h20, 32'h0, 0);
        access(1'b0, 1'b1, 32'h22, 32'hCAFEF00D, 0);
        access(1'b1, 1'b0, 32'h20, 32'h0, 0);
        access(1'b1, 1'b0, 32'h4, 32'h0, LAT + 1);
        access(1'b1, 1'b0, 32'h4, 32'h0, 0);

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)
                a = (32'($urandom_range(1, 255)) << 10) | (32'($urandom_range(0, 255)) << 2);
            else if (sel == 1)
                a = pool_addr() + 32'($urandom_range(1, 3));
            else
                a = pool_addr();
            sel = $urandom_range(0, 7);
            rd  = (sel == 0) || (sel >= 4);
            wr  = (sel <= 3);
            access(rd, wr, a, $urandom,
                   ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, LAT + 1)) : 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("idle_stall", {31'h0, bus.stall_o}, 32'h0);
                check("idle_ack",   {31'h0, bus.ack_o},   32'h0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
